// File: rtl/dram_burst_reader.sv
// Burst read engine: turns a (base, length) request into throttled dram reads and
// streams the returned bytes out through a small FIFO on a valid/ready interface.
module dram_burst_reader #(
  parameter int A_WIDTH    = 20,
  parameter int D_WIDTH    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [A_WIDTH-1:0] base_addr_i,
  input  logic [A_WIDTH:0]   length_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               mem_ren_o,
  output logic [A_WIDTH-1:0] mem_raddr_o,
  input  logic [D_WIDTH-1:0] mem_rdata_i,
  output logic               out_valid_o,
  output logic [D_WIDTH-1:0] out_data_o,
  input  logic               out_ready_i,
  output logic [1:0]         state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  localparam logic [OCC_W-1:0]   DEPTH_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   ONE_CNT   = CNT_W'(1);
  localparam logic [A_WIDTH:0]   ONE_REQ   = (A_WIDTH+1)'(1);
  localparam logic [A_WIDTH-1:0] ONE_ADDR  = A_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e             state_q;
  logic [A_WIDTH-1:0] addr_q;
  logic [A_WIDTH:0]   reqs_left_q;
  logic               inflight_q;
  logic               done_q;

  logic [D_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  logic               pop;
  logic               push;
  logic               issue;
  logic               last_pop;
  logic [OCC_W-1:0]   occupancy;

  // Output stream: a byte moves when out_valid_o and out_ready_i are both high at a
  // rising edge; out_data_o holds the FIFO head and cannot change until it is taken.
  always_comb begin
    pop       = (count_q != '0) & out_ready_i;
    push      = inflight_q;
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    // A slot freed by this cycle's pop may be reserved by this cycle's request.
    issue     = (state_q == S_READ) && (reqs_left_q != '0) &&
                (occupancy < (DEPTH_OCC + {{CNT_W{1'b0}}, pop}));
    last_pop  = (state_q == S_DRAIN) && pop && !inflight_q && (count_q == ONE_CNT);
    count_d   = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      reqs_left_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (length_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= S_READ;
              addr_q      <= base_addr_i;
              reqs_left_q <= length_i;
            end
          end
        end
        S_READ: begin
          if (issue) begin
            addr_q      <= addr_q + ONE_ADDR;
            reqs_left_q <= reqs_left_q - ONE_REQ;
            if (reqs_left_q == ONE_REQ) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (last_pop) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing reads an entry before it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

  assert property (@(posedge clk) disable iff (rst) push |-> (count_q < DEPTH_CNT));

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign mem_ren_o   = issue;
  assign mem_raddr_o = addr_q;
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = (count_q != '0) ? fifo_q[rd_ptr_q] : '0;
  assign state_o     = state_q;

endmodule

// File: tb/tb_dram_burst_reader.sv
// Bench for dram_burst_reader: a table of transfers, randomized transfers and a
// mid-burst reset, all checked against a byte-level model of memory and FIFO occupancy.
module tb_dram_burst_reader;

  localparam int AW = 20;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW:0]   length_i;
  logic          busy_o;
  logic          done_o;
  logic          mem_ren_o;
  logic [AW-1:0] mem_raddr_o;
  logic [DW-1:0] mem_rdata_i;
  logic          out_valid_o;
  logic [DW-1:0] out_data_o;
  logic          out_ready_i;
  logic [1:0]    state_o;

  dram_burst_reader #(.A_WIDTH(AW), .D_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .start_i(start_i), .base_addr_i(base_addr_i), .length_i(length_i),
    .busy_o(busy_o), .done_o(done_o),
    .mem_ren_o(mem_ren_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .state_o(state_o)
  );

  // ---------------- clock / reset / dram model ----------------
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_ren_o) mem_rdata_i <= mem[mem_raddr_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  bit            mon_en = 1'b0;
  int            x_ren, x_pop, x_done, first_ren_cyc, first_pop_cyc, done_cyc;
  bit            x_busy;
  int            ren_total, pop_total, stored;
  bit            ren_prev;
  logic [DW-1:0] mon_b;
  logic [AW-1:0] mon_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_addr_q.delete();
    ren_total = 0;
    pop_total = 0;
    ren_prev  = 1'b0;
  endtask

  // Monitor: samples mid-cycle. FIFO fill = bytes requested at least two cycles ago
  // minus bytes already taken.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      stored = ren_total - int'(ren_prev) - pop_total;
      check("fifo_bound", 32'(stored <= DEPTH), 1);
      check("out_valid", 32'(out_valid_o), 32'(stored != 0));
      if (mem_ren_o) begin
        if (first_ren_cyc < 0) first_ren_cyc = cyc;
        x_ren++;
        if (exp_addr_q.size() == 0) begin
          check("extra_mem_ren", 32'(mem_raddr_o), 32'hFFFFFFFF);
        end else begin
          mon_a = exp_addr_q.pop_front();
          check("mem_raddr", 32'(mem_raddr_o), 32'(mon_a));
        end
      end
      if (out_valid_o && out_ready_i) begin
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        x_pop++;
        if (exp_q.size() == 0) begin
          check("extra_byte", 32'(out_data_o), 32'hFFFFFFFF);
        end else begin
          mon_b = exp_q.pop_front();
          check("out_data", 32'(out_data_o), 32'(mon_b));
        end
      end
      if (done_o) begin
        x_done++;
        done_cyc = cyc;
      end
      if (busy_o) x_busy = 1'b1;
      ren_total += int'(mem_ren_o);
      pop_total += int'(out_valid_o && out_ready_i);
      ren_prev   = mem_ren_o;
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            pct;           // out_ready probability in percent
    bit            noise;         // pulse start with junk while busy
    int            exp_done_lat;  // cycles from start cycle to done cycle, -1 = unchecked
    int            exp_first_pop; // cycles from start cycle to first byte, -1 = unchecked
    string         name;
  } vec_t;

  function automatic bit rdy(input int pct);
    return $urandom_range(1, 100) <= pct;
  endfunction

  task automatic run_xfer(input vec_t v);
    int c0;
    int k;
    int budget;
    logic [AW-1:0] a;
    budget = 40 + v.len * 40;
    for (int i = 0; i < v.len; i++) begin
      a = v.base + AW'(i);
      exp_q.push_back(mem[a]);
      exp_addr_q.push_back(a);
    end
    x_ren = 0; x_pop = 0; x_done = 0; x_busy = 1'b0;
    first_ren_cyc = -1; first_pop_cyc = -1; done_cyc = -1;
    @(posedge clk); #1;
    start_i     = 1'b1;
    base_addr_i = v.base;
    length_i    = (AW+1)'(v.len);
    out_ready_i = rdy(v.pct);
    c0 = cyc;
    @(posedge clk); #1;
    k = 0;
    while (x_done == 0 && k < budget) begin
      out_ready_i = rdy(v.pct);
      if (v.noise && busy_o && $urandom_range(0, 2) == 0) begin
        start_i     = 1'b1;
        base_addr_i = AW'($urandom);
        length_i    = (AW+1)'($urandom_range(1, 30));
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start_i = 1'b0;
    check({v.name, "_done_seen"}, 32'(x_done != 0), 1);
    repeat (3) begin
      out_ready_i = rdy(v.pct);
      @(posedge clk); #1;
    end
    check({v.name, "_done_count"}, 32'(x_done), 1);
    check({v.name, "_ren_count"}, 32'(x_ren), 32'(v.len));
    check({v.name, "_byte_count"}, 32'(x_pop), 32'(v.len));
    check({v.name, "_left_over"}, 32'(exp_q.size() + exp_addr_q.size()), 0);
    check({v.name, "_busy_after"}, 32'(busy_o), 0);
    check({v.name, "_busy_seen"}, 32'(x_busy), 32'(v.len != 0));
    if (v.len != 0) check({v.name, "_first_ren"}, 32'(first_ren_cyc - c0), 1);
    if (v.exp_done_lat >= 0) check({v.name, "_done_lat"}, 32'(done_cyc - c0), 32'(v.exp_done_lat));
    if (v.exp_first_pop >= 0) check({v.name, "_first_pop"}, 32'(first_pop_cyc - c0), 32'(v.exp_first_pop));
    clear_model();
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; length_i = '0; out_ready_i = 1'b0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'((a * 37) ^ (a >> 8) ^ ((a >> 16) * 5));
    mem[20'h00010] = 8'h11; mem[20'h00011] = 8'h22;
    mem[20'h00012] = 8'h33; mem[20'h00013] = 8'h44;

    tbl[0] = '{20'h00010, 4,  100, 1'b0, 7,  3,  "basic4"};
    tbl[1] = '{20'h00010, 16, 50,  1'b0, -1, -1, "throttle16"};
    tbl[2] = '{20'hFFFFE, 4,  100, 1'b0, 7,  3,  "wrap4"};
    tbl[3] = '{20'h00010, 0,  100, 1'b0, 1,  -1, "len0"};
    tbl[4] = '{20'h00010, 16, 70,  1'b1, -1, -1, "start_busy"};
    tbl[5] = '{20'hFFFFF, 1,  100, 1'b0, 4,  3,  "single"};
    tbl[6] = '{20'h00300, 12, 100, 1'b1, 15, 3,  "stream12"};

    #1;
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_mem_ren", 32'(mem_ren_o), 0);
    check("rst_mem_raddr", 32'(mem_raddr_o), 0);
    check("rst_out_valid", 32'(out_valid_o), 0);
    check("rst_out_data", 32'(out_data_o), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    clear_model();
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) run_xfer(tbl[i]);

    for (int r = 0; r < 14; r++) begin
      rv.base  = ($urandom_range(0, 3) == 0) ? 20'hFFFF0 + AW'($urandom_range(0, 15)) : AW'($urandom);
      rv.len   = $urandom_range(0, 24);
      rv.pct   = ($urandom_range(0, 2) == 0) ? 100 : $urandom_range(20, 95);
      rv.noise = 1'($urandom_range(0, 1));
      rv.exp_done_lat  = (rv.pct == 100) ? ((rv.len == 0) ? 1 : rv.len + 3) : -1;
      rv.exp_first_pop = (rv.pct == 100 && rv.len > 0) ? 3 : -1;
      rv.name  = "rand";
      run_xfer(rv);
    end

    // Mid-burst reset with a full FIFO and a request being issued.
    mon_en = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = 20'h00010; length_i = 21'd16; out_ready_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (6) @(posedge clk);
    #1 out_ready_i = 1'b1;
    #1;
    check("pre_rst_valid", 32'(out_valid_o), 1);
    check("pre_rst_ren", 32'(mem_ren_o), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_done", 32'(done_o), 0);
    check("mid_rst_mem_ren", 32'(mem_ren_o), 0);
    check("mid_rst_mem_raddr", 32'(mem_raddr_o), 0);
    check("mid_rst_out_valid", 32'(out_valid_o), 0);
    check("mid_rst_out_data", 32'(out_data_o), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    out_ready_i = 1'b0;
    clear_model();
    mon_en = 1'b1;
    rv = '{20'h00020, 3, 100, 1'b0, 6, 3, "after_rst"};
    run_xfer(rv);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
